// File: rtl/rat_ckpt_pkg.sv
// Shared types for the register alias table and its branch checkpoints.
// Holds the physical register width, the CDB broadcast record and the table snapshot type.
package rat_ckpt_pkg;

    localparam int ARCH_REGS = 32;
    localparam int AREG_W    = 5;
    localparam int PR_WIDTH  = 6;

    // One CDB broadcast: producer arch reg and the phys reg it wrote
    typedef struct packed {
        logic                cdb_valid;
        logic [AREG_W-1:0]   arch_reg;
        logic [PR_WIDTH-1:0] phys_reg;
    } cdb_t;

    // Full alias table image, used for the live table and for every checkpoint
    typedef struct packed {
        logic [ARCH_REGS-1:0][PR_WIDTH-1:0] map;
        logic [ARCH_REGS-1:0]               valid;
    } rat_ckpt_t;

    // Marks an entry ready only while it still names the broadcast phys reg,
    // so a wakeup for a superseded mapping is ignored
    function automatic rat_ckpt_t cdbWakeup(input rat_ckpt_t tbl, input cdb_t bcast);
        rat_ckpt_t res;
        res = tbl;
        if (bcast.cdb_valid && (tbl.map[bcast.arch_reg] == bcast.phys_reg)) begin
            res.valid[bcast.arch_reg] = 1'b1;
        end
        return res;
    endfunction

    // Identity mapping with every register ready
    function automatic rat_ckpt_t resetTable();
        rat_ckpt_t res;
        for (int i = 0; i < ARCH_REGS; i++) begin
            res.map[i]   = PR_WIDTH'(i);
            res.valid[i] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rat_ckpt_ctrl.sv
// Circular FIFO bookkeeping for the checkpoint slots: head, tail and occupancy,
// with the allocate / release / restore pointer arithmetic.
module rat_ckpt_ctrl import rat_ckpt_pkg::*; #(
    parameter int NUM_CKPT = 4,
    parameter int ID_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ckptReq_i,
    input  logic            ckptRelease_i,
    input  logic            restoreValid_i,
    input  logic [ID_W-1:0] restoreId_i,
    output logic            ckptReady_o,
    output logic [ID_W-1:0] ckptTail_o,
    output logic            ckptAlloc_o
);

    localparam int CNT_W = $clog2(NUM_CKPT + 1);

    logic [ID_W-1:0]  head_q, head_d;
    logic [ID_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             relEff;
    logic             allocEff;
    logic             full;

    function automatic logic [ID_W-1:0] nextPtr(input logic [ID_W-1:0] p);
        return (p == ID_W'(NUM_CKPT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (count_q == CNT_W'(NUM_CKPT));
    assign ckptReady_o = !full;
    assign ckptTail_o  = tail_q;
    assign ckptAlloc_o = allocEff;

    // Next pointer state; restore wins over allocate and rewinds the tail to the restored slot
    always_comb begin
        relEff   = ckptRelease_i && (count_q != '0);
        allocEff = ckptReq_i && !full && !restoreValid_i;
        head_d   = relEff ? nextPtr(head_q) : head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (restoreValid_i) begin
            tail_d = restoreId_i;
            if (restoreId_i >= head_d) begin
                count_d = CNT_W'(restoreId_i) - CNT_W'(head_d);
            end else begin
                count_d = CNT_W'(NUM_CKPT) + CNT_W'(restoreId_i) - CNT_W'(head_d);
            end
        end else begin
            tail_d  = allocEff ? nextPtr(tail_q) : tail_q;
            count_d = count_q + CNT_W'(allocEff) - CNT_W'(relEff);
        end
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rat_ckpt.sv
// Multi-issue register alias table with in-place branch checkpoints.
// Renames DISPATCH_W instructions per cycle, absorbs CDB_W wakeups per cycle,
// and restores the whole map from a snapshot in a single cycle on mispredict.
module rat_ckpt import rat_ckpt_pkg::*; #(
    parameter int DISPATCH_W = 2,
    parameter int CDB_W      = 2,
    parameter int NUM_CKPT   = 4,
    parameter int SLOT_W     = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1,
    parameter int ID_W       = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DISPATCH_W-1:0]                disp_we,
    input  logic [DISPATCH_W-1:0][AREG_W-1:0]    disp_rd,
    input  logic [DISPATCH_W-1:0][PR_WIDTH-1:0]  disp_pd,
    input  logic [DISPATCH_W-1:0][AREG_W-1:0]    disp_rs1,
    input  logic [DISPATCH_W-1:0][AREG_W-1:0]    disp_rs2,
    output logic [DISPATCH_W-1:0][PR_WIDTH-1:0]  ps1,
    output logic [DISPATCH_W-1:0][PR_WIDTH-1:0]  ps2,
    output logic [DISPATCH_W-1:0]                ps1_valid,
    output logic [DISPATCH_W-1:0]                ps2_valid,
    input  cdb_t [CDB_W-1:0]                     cdb,
    input  logic                                 ckpt_req,
    input  logic [SLOT_W-1:0]                    ckpt_slot,
    output logic                                 ckpt_ready,
    output logic [ID_W-1:0]                      ckpt_id,
    input  logic                                 ckpt_release,
    input  logic                                 restore_valid,
    input  logic [ID_W-1:0]                      restore_id
);

    rat_ckpt_t live_q, live_d;
    rat_ckpt_t ckpt_q [NUM_CKPT];
    rat_ckpt_t ckpt_d [NUM_CKPT];
    rat_ckpt_t snoopTbl [NUM_CKPT];
    rat_ckpt_t wakeTbl, renTbl, snapTbl;
    logic      ckptAlloc;
    logic [DISPATCH_W-1:0][PR_WIDTH:0] src1Look, src2Look;

    rat_ckpt_ctrl #(
        .NUM_CKPT (NUM_CKPT),
        .ID_W     (ID_W)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .ckptReq_i      (ckpt_req),
        .ckptRelease_i  (ckpt_release),
        .restoreValid_i (restore_valid),
        .restoreId_i    (restore_id),
        .ckptReady_o    (ckpt_ready),
        .ckptTail_o     (ckpt_id),
        .ckptAlloc_o    (ckptAlloc)
    );

    // Source lookup for one slot: table value, then CDB readiness bypass, then the
    // youngest older slot in the same group that writes this register; x0 is hardwired
    function automatic logic [PR_WIDTH:0] lookupSrc(
        input logic [AREG_W-1:0]                   rs,
        input int                                  slot,
        input rat_ckpt_t                           tbl,
        input cdb_t [CDB_W-1:0]                    bus,
        input logic [DISPATCH_W-1:0]               we,
        input logic [DISPATCH_W-1:0][AREG_W-1:0]   rd,
        input logic [DISPATCH_W-1:0][PR_WIDTH-1:0] pd
    );
        logic [PR_WIDTH-1:0] ps;
        logic                rdy;
        ps  = tbl.map[rs];
        rdy = tbl.valid[rs];
        for (int k = 0; k < CDB_W; k++) begin
            if (bus[k].cdb_valid && (bus[k].arch_reg == rs) && (tbl.map[rs] == bus[k].phys_reg)) begin
                rdy = 1'b1;
            end
        end
        for (int j = 0; j < DISPATCH_W; j++) begin
            if ((j < slot) && we[j] && (rd[j] == rs) && (rs != '0)) begin
                ps  = pd[j];
                rdy = 1'b0;
            end
        end
        if (rs == '0) begin
            ps  = '0;
            rdy = 1'b1;
        end
        return {rdy, ps};
    endfunction

    // Combinational rename read ports
    always_comb begin
        for (int i = 0; i < DISPATCH_W; i++) begin
            src1Look[i]  = lookupSrc(disp_rs1[i], i, live_q, cdb, disp_we, disp_rd, disp_pd);
            src2Look[i]  = lookupSrc(disp_rs2[i], i, live_q, cdb, disp_we, disp_rd, disp_pd);
            ps1[i]       = src1Look[i][PR_WIDTH-1:0];
            ps1_valid[i] = src1Look[i][PR_WIDTH];
            ps2[i]       = src2Look[i][PR_WIDTH-1:0];
            ps2_valid[i] = src2Look[i][PR_WIDTH];
        end
    end

    // Live table update: wakeups first, then renames in slot order; the snapshot
    // is tapped after the last slot that belongs to the checkpointed branch
    always_comb begin
        wakeTbl = live_q;
        for (int k = 0; k < CDB_W; k++) begin
            wakeTbl = cdbWakeup(wakeTbl, cdb[k]);
        end
        renTbl  = wakeTbl;
        snapTbl = wakeTbl;
        for (int j = 0; j < DISPATCH_W; j++) begin
            if (disp_we[j] && (disp_rd[j] != '0)) begin
                renTbl.map[disp_rd[j]]   = disp_pd[j];
                renTbl.valid[disp_rd[j]] = 1'b0;
            end
            if (SLOT_W'(j) == ckpt_slot) begin
                snapTbl = renTbl;
            end
        end
    end

    // Checkpoints snoop the CDB every cycle so a restore never brings back stale not-ready bits;
    // a restore takes the snooped image and discards this cycle's renames
    always_comb begin
        for (int n = 0; n < NUM_CKPT; n++) begin
            snoopTbl[n] = ckpt_q[n];
            for (int k = 0; k < CDB_W; k++) begin
                snoopTbl[n] = cdbWakeup(snoopTbl[n], cdb[k]);
            end
            ckpt_d[n] = snoopTbl[n];
        end
        if (ckptAlloc) begin
            ckpt_d[ckpt_id] = snapTbl;
        end
        live_d = restore_valid ? snoopTbl[restore_id] : renTbl;
    end

    // Live alias table register
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= resetTable();
        end else begin
            live_q <= live_d;
        end
    end

    // Checkpoint storage; contents of free slots are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_CKPT; n++) begin
            ckpt_q[n] <= ckpt_d[n];
        end
    end

endmodule

// File: tb/tb_rat_ckpt.sv
// Self-checking bench for rat_ckpt: directed scenarios followed by random traffic,
// all compared against a behavioural alias-table model with a queue of live checkpoints.
module tb_rat_ckpt;
    import rat_ckpt_pkg::*;

    localparam int DW = 2;
    localparam int CW = 2;
    localparam int NC = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [DW-1:0]               disp_we;
    logic [DW-1:0][AREG_W-1:0]   disp_rd, disp_rs1, disp_rs2;
    logic [DW-1:0][PR_WIDTH-1:0] disp_pd;
    logic [DW-1:0][PR_WIDTH-1:0] ps1, ps2;
    logic [DW-1:0]               ps1_valid, ps2_valid;
    cdb_t [CW-1:0]               cdb;
    logic                        ckpt_req;
    logic [0:0]                  ckpt_slot;
    logic                        ckpt_ready;
    logic [1:0]                  ckpt_id;
    logic                        ckpt_release;
    logic                        restore_valid;
    logic [1:0]                  restore_id;

    int total = 0;
    int bad   = 0;

    // Reference model: live map plus checkpoint images and an ordered list of live ids
    int mMap[ARCH_REGS];
    bit mValid[ARCH_REGS];
    int cMap[NC][ARCH_REGS];
    bit cValid[NC][ARCH_REGS];
    int liveQ[$];
    int nextId;

    rat_ckpt #(.DISPATCH_W(DW), .CDB_W(CW), .NUM_CKPT(NC)) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_we       (disp_we),
        .disp_rd       (disp_rd),
        .disp_pd       (disp_pd),
        .disp_rs1      (disp_rs1),
        .disp_rs2      (disp_rs2),
        .ps1           (ps1),
        .ps2           (ps2),
        .ps1_valid     (ps1_valid),
        .ps2_valid     (ps2_valid),
        .cdb           (cdb),
        .ckpt_req      (ckpt_req),
        .ckpt_slot     (ckpt_slot),
        .ckpt_ready    (ckpt_ready),
        .ckpt_id       (ckpt_id),
        .ckpt_release  (ckpt_release),
        .restore_valid (restore_valid),
        .restore_id    (restore_id)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        rst           = 1'b0;
        disp_we       = '0;
        disp_rd       = '0;
        disp_pd       = '0;
        disp_rs1      = '0;
        disp_rs2      = '0;
        cdb           = '0;
        ckpt_req      = 1'b0;
        ckpt_slot     = '0;
        ckpt_release  = 1'b0;
        restore_valid = 1'b0;
        restore_id    = '0;
    endtask

    task automatic setCdb(input int k, input int arch, input int phys);
        cdb[k].cdb_valid = 1'b1;
        cdb[k].arch_reg  = AREG_W'(arch);
        cdb[k].phys_reg  = PR_WIDTH'(phys);
    endtask

    task automatic modelReset();
        for (int a = 0; a < ARCH_REGS; a++) begin
            mMap[a]   = a;
            mValid[a] = 1'b1;
        end
        liveQ.delete();
        nextId = 0;
    endtask

    // Expected lookup result for source register rs in slot i
    task automatic expRead(input int i, input int rs, output int ps, output int v);
        if (rs == 0) begin
            ps = 0;
            v  = 1;
            return;
        end
        ps = mMap[rs];
        v  = mValid[rs] ? 1 : 0;
        for (int k = 0; k < CW; k++) begin
            if (cdb[k].cdb_valid && int'(cdb[k].arch_reg) == rs && int'(cdb[k].phys_reg) == mMap[rs]) v = 1;
        end
        for (int j = 0; j < i; j++) begin
            if (disp_we[j] && int'(disp_rd[j]) == rs) begin
                ps = int'(disp_pd[j]);
                v  = 0;
            end
        end
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic commitModel();
        int  snapMap[ARCH_REGS];
        bit  snapValid[ARCH_REGS];
        int  pos, sz, arch, rid;
        bit  doRel, doAlloc;
        if (rst) begin
            modelReset();
            return;
        end
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < CW; k++) begin
                arch = int'(cdb[k].arch_reg);
                if (cdb[k].cdb_valid && cMap[c][arch] == int'(cdb[k].phys_reg)) cValid[c][arch] = 1'b1;
            end
        end
        if (restore_valid) begin
            rid = int'(restore_id);
            if (ckpt_release && liveQ.size() > 0) void'(liveQ.pop_front());
            pos = 0;
            while (pos < liveQ.size() && liveQ[pos] != rid) pos++;
            while (liveQ.size() > pos) void'(liveQ.pop_back());
            nextId = rid;
            for (int a = 0; a < ARCH_REGS; a++) begin
                mMap[a]   = cMap[rid][a];
                mValid[a] = cValid[rid][a];
            end
            return;
        end
        for (int k = 0; k < CW; k++) begin
            arch = int'(cdb[k].arch_reg);
            if (cdb[k].cdb_valid && mMap[arch] == int'(cdb[k].phys_reg)) mValid[arch] = 1'b1;
        end
        for (int a = 0; a < ARCH_REGS; a++) begin
            snapMap[a]   = mMap[a];
            snapValid[a] = mValid[a];
        end
        for (int j = 0; j < DW; j++) begin
            if (disp_we[j] && disp_rd[j] != 0) begin
                mMap[int'(disp_rd[j])]   = int'(disp_pd[j]);
                mValid[int'(disp_rd[j])] = 1'b0;
            end
            if (j == int'(ckpt_slot)) begin
                for (int a = 0; a < ARCH_REGS; a++) begin
                    snapMap[a]   = mMap[a];
                    snapValid[a] = mValid[a];
                end
            end
        end
        sz      = liveQ.size();
        doRel   = ckpt_release && sz > 0;
        doAlloc = ckpt_req && sz < NC;
        if (doRel) void'(liveQ.pop_front());
        if (doAlloc) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                cMap[nextId][a]   = snapMap[a];
                cValid[nextId][a] = snapValid[a];
            end
            liveQ.push_back(nextId);
            nextId = (nextId + 1) % NC;
        end
    endtask

    // Check every output against the model, then clock the step in
    task automatic applyStimulus(input string tag);
        int eps, ev;
        #1;
        for (int i = 0; i < DW; i++) begin
            expRead(i, int'(disp_rs1[i]), eps, ev);
            checkOutput($sformatf("%s_ps1_%0d", tag, i), 32'(ps1[i]), eps);
            checkOutput($sformatf("%s_ps1v_%0d", tag, i), 32'(ps1_valid[i]), ev);
            expRead(i, int'(disp_rs2[i]), eps, ev);
            checkOutput($sformatf("%s_ps2_%0d", tag, i), 32'(ps2[i]), eps);
            checkOutput($sformatf("%s_ps2v_%0d", tag, i), 32'(ps2_valid[i]), ev);
        end
        checkOutput({tag, "_ready"}, 32'(ckpt_ready), (liveQ.size() < NC) ? 1 : 0);
        checkOutput({tag, "_id"}, 32'(ckpt_id), nextId);
        commitModel();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int idx, arch;
        clearInputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        modelReset();
        rst = 1'b0;

        // Reset state and x0 read
        clearInputs();
        disp_rs1[0] = 5;
        #1;
        checkOutput("t1_ps1", 32'(ps1[0]), 5);
        checkOutput("t1_ps1v", 32'(ps1_valid[0]), 1);
        checkOutput("t1_ps2", 32'(ps2[0]), 0);
        checkOutput("t1_ps2v", 32'(ps2_valid[0]), 1);
        checkOutput("t1_ready", 32'(ckpt_ready), 1);
        checkOutput("t1_id", 32'(ckpt_id), 0);
        applyStimulus("t1");

        // Intra-group bypass, then CDB readiness bypass and latch
        clearInputs();
        disp_we[0] = 1'b1; disp_rd[0] = 3; disp_pd[0] = 40; disp_rs1[1] = 3;
        #1;
        checkOutput("t2_byp_ps", 32'(ps1[1]), 40);
        checkOutput("t2_byp_v", 32'(ps1_valid[1]), 0);
        applyStimulus("t2a");
        clearInputs();
        setCdb(0, 3, 40); disp_rs1[0] = 3;
        #1;
        checkOutput("t2_cdb_ps", 32'(ps1[0]), 40);
        checkOutput("t2_cdb_v", 32'(ps1_valid[0]), 1);
        applyStimulus("t2b");
        clearInputs();
        disp_rs1[0] = 3;
        #1;
        checkOutput("t2_latched_v", 32'(ps1_valid[0]), 1);
        applyStimulus("t2c");

        // Checkpoint covering slot 0 only, then restore it
        clearInputs();
        disp_we = 2'b11; disp_rd[0] = 7; disp_pd[0] = 41; disp_rd[1] = 8; disp_pd[1] = 42;
        ckpt_req = 1'b1; ckpt_slot = 0;
        #1;
        checkOutput("t3_id", 32'(ckpt_id), 0);
        applyStimulus("t3a");
        clearInputs();
        disp_rs1[0] = 8; restore_valid = 1'b1; restore_id = 0;
        #1;
        checkOutput("t3_pre_ps", 32'(ps1[0]), 42);
        applyStimulus("t3b");
        clearInputs();
        disp_rs1[0] = 7; disp_rs2[0] = 8;
        #1;
        checkOutput("t3_map7", 32'(ps1[0]), 41);
        checkOutput("t3_map8", 32'(ps2[0]), 8);
        checkOutput("t3_val8", 32'(ps2_valid[0]), 1);
        applyStimulus("t3c");

        // Checkpoint with p41 in flight, wakeup lands, restore sees it ready
        clearInputs();
        ckpt_req = 1'b1; ckpt_slot = 0; disp_we[1] = 1'b1; disp_rd[1] = 7; disp_pd[1] = 43;
        applyStimulus("t4a");
        clearInputs();
        setCdb(0, 7, 41); disp_rs1[0] = 7;
        #1;
        checkOutput("t4_live_ps", 32'(ps1[0]), 43);
        checkOutput("t4_live_v", 32'(ps1_valid[0]), 0);
        applyStimulus("t4b");
        clearInputs();
        restore_valid = 1'b1; restore_id = 0;
        applyStimulus("t4c");
        clearInputs();
        disp_rs1[0] = 7;
        #1;
        checkOutput("t4_rest_ps", 32'(ps1[0]), 41);
        checkOutput("t4_rest_v", 32'(ps1_valid[0]), 1);
        applyStimulus("t4d");

        // Fill all slots, drop an extra request, release and wrap
        for (int c = 0; c < NC; c++) begin
            clearInputs();
            ckpt_req = 1'b1;
            #1;
            checkOutput($sformatf("t5_id%0d", c), 32'(ckpt_id), c);
            applyStimulus($sformatf("t5_fill%0d", c));
        end
        clearInputs();
        ckpt_req = 1'b1;
        #1;
        checkOutput("t5_full_ready", 32'(ckpt_ready), 0);
        applyStimulus("t5_drop");
        clearInputs();
        ckpt_release = 1'b1;
        applyStimulus("t5_rel");
        clearInputs();
        #1;
        checkOutput("t5_wrap_ready", 32'(ckpt_ready), 1);
        checkOutput("t5_wrap_id", 32'(ckpt_id), 0);
        applyStimulus("t5_wrap");

        // Restore discards same-cycle dispatch and request; middle restore leaves one live
        clearInputs();
        rst = 1'b1;
        applyStimulus("t6_rst");
        for (int c = 0; c < 3; c++) begin
            clearInputs();
            ckpt_req = 1'b1;
            applyStimulus($sformatf("t6_alloc%0d", c));
        end
        clearInputs();
        restore_valid = 1'b1; restore_id = 1; ckpt_req = 1'b1;
        disp_we[0] = 1'b1; disp_rd[0] = 9; disp_pd[0] = 50;
        applyStimulus("t6_rest");
        clearInputs();
        disp_rs1[0] = 9;
        #1;
        checkOutput("t6_map9", 32'(ps1[0]), 9);
        checkOutput("t6_id", 32'(ckpt_id), 1);
        applyStimulus("t6_read");
        for (int c = 0; c < 3; c++) begin
            clearInputs();
            ckpt_req = 1'b1;
            applyStimulus($sformatf("t6_refill%0d", c));
        end
        clearInputs();
        #1;
        checkOutput("t6_full", 32'(ckpt_ready), 0);
        applyStimulus("t6_end");

        // Random traffic with a small register window to force collisions
        for (int cyc = 0; cyc < 400; cyc++) begin
            clearInputs();
            for (int i = 0; i < DW; i++) begin
                disp_we[i]  = 1'($urandom_range(0, 1));
                disp_rd[i]  = AREG_W'($urandom_range(0, 7));
                disp_pd[i]  = PR_WIDTH'($urandom);
                disp_rs1[i] = AREG_W'($urandom_range(0, 7));
                disp_rs2[i] = AREG_W'($urandom_range(0, 7));
            end
            for (int k = 0; k < CW; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    arch = $urandom_range(0, 7);
                    if (liveQ.size() > 0 && $urandom_range(0, 3) == 0) begin
                        setCdb(k, arch, cMap[liveQ[$urandom_range(0, liveQ.size() - 1)]][arch]);
                    end else if ($urandom_range(0, 3) != 0) begin
                        setCdb(k, arch, mMap[arch]);
                    end else begin
                        setCdb(k, arch, $urandom_range(0, 63));
                    end
                end
            end
            ckpt_req     = ($urandom_range(0, 2) == 0);
            ckpt_slot    = 1'($urandom_range(0, 1));
            ckpt_release = ($urandom_range(0, 4) == 0);
            if (liveQ.size() > 0 && $urandom_range(0, 7) == 0) begin
                idx           = $urandom_range(0, liveQ.size() - 1);
                restore_valid = 1'b1;
                restore_id    = 2'(liveQ[idx]);
                if (idx == 0) ckpt_release = 1'b0;
            end
            if (cyc % 150 == 149) rst = 1'b1;
            applyStimulus($sformatf("r%0d", cyc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
